// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between three message sources.
// Streams the winner's bytes under the partida_tx/pronto_tx handshake with a per-byte timeout.
module serial_tx_arbiter #(
   parameter int unsigned TIMEOUT = 50000,
   parameter int unsigned CW      = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic [3:0] len2,
   input  logic [7:0] dado0,
   input  logic [7:0] dado1,
   input  logic [7:0] dado2,
   input  logic       pronto_tx,
   output logic [2:0] grant,
   output logic [3:0] byte_idx,
   output logic [2:0] fim,
   output logic       partida_tx,
   output logic [7:0] dado_tx,
   output logic       erro_tx,
   output logic       ocupado,
   output logic [2:0] db_estado
);

   localparam logic [2:0] INICIAL = 3'd0;
   localparam logic [2:0] CARREGA = 3'd1;
   localparam logic [2:0] ENVIA   = 3'd2;
   localparam logic [2:0] ESPERA  = 3'd3;
   localparam logic [2:0] FIM     = 3'd4;
   localparam logic [2:0] ERRO    = 3'd5;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [2:0]    state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    len_q, len_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    dado_q, dado_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          win_valid;
   logic [1:0]    win;
   logic [3:0]    win_len;
   logic [7:0]    sel_dado;
   logic [2:0]    sel_onehot;

   // (p + k) mod 3 for p in 0..3, k in 1..3
   function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= 3'd6) begin
         s = s - 3'd6;
      end else if (s >= 3'd3) begin
         s = s - 3'd3;
      end
      return s[1:0];
   endfunction

   // Scan from the farthest candidate down so the nearest requester after ptr wins.
   always_comb begin
      logic [1:0] c;
      win_valid = 1'b0;
      win       = 2'd0;
      c         = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         c = rr_idx(ptr_q, 2'(k));
         if (req[c]) begin
            win_valid = 1'b1;
            win       = c;
         end
      end
   end

   always_comb begin
      case (win)
         2'd0:    win_len = len0;
         2'd1:    win_len = len1;
         default: win_len = len2;
      endcase
   end

   always_comb begin
      case (sel_q)
         2'd0:    sel_dado = dado0;
         2'd1:    sel_dado = dado1;
         default: sel_dado = dado2;
      endcase
   end

   always_comb begin
      case (sel_q)
         2'd0:    sel_onehot = 3'b001;
         2'd1:    sel_onehot = 3'b010;
         2'd2:    sel_onehot = 3'b100;
         default: sel_onehot = 3'b000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      len_d   = len_q;
      idx_d   = idx_q;
      dado_d  = dado_q;
      cnt_d   = cnt_q;
      case (state_q)
         INICIAL: begin
            if (win_valid) begin
               sel_d   = win;
               len_d   = win_len;
               idx_d   = 4'd0;
               state_d = (win_len == 4'd0) ? FIM : CARREGA;
            end
         end
         CARREGA: begin
            dado_d  = sel_dado;
            state_d = ENVIA;
         end
         ENVIA: begin
            cnt_d   = '0;
            state_d = ESPERA;
         end
         ESPERA: begin
            // A pronto_tx arriving on the last allowed cycle still counts as success.
            if (pronto_tx) begin
               if (idx_q == len_q - 4'd1) begin
                  state_d = FIM;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = CARREGA;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERRO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FIM, ERRO: begin
            ptr_d   = sel_q;
            state_d = INICIAL;
         end
         default: state_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INICIAL;
         ptr_q   <= 2'd2;
         sel_q   <= 2'd0;
         len_q   <= 4'd0;
         idx_q   <= 4'd0;
         dado_q  <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         dado_q  <= dado_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      grant      = 3'b000;
      fim        = 3'b000;
      partida_tx = 1'b0;
      erro_tx    = 1'b0;
      case (state_q)
         CARREGA, ESPERA: grant = sel_onehot;
         ENVIA: begin
            grant      = sel_onehot;
            partida_tx = 1'b1;
         end
         FIM: begin
            grant = sel_onehot;
            fim   = sel_onehot;
         end
         ERRO: begin
            grant   = sel_onehot;
            fim     = sel_onehot;
            erro_tx = 1'b1;
         end
         default: grant = 3'b000;
      endcase
   end

   assign ocupado   = (state_q != INICIAL);
   assign db_estado = state_q;
   assign byte_idx  = idx_q;
   assign dado_tx   = dado_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: stimulus queues expected bytes/completions,
// a negedge monitor pops and compares them whenever the DUT starts a byte or ends a message.
module tb_serial_tx_arbiter;

   logic       clock;
   logic       reset;
   logic [2:0] req;
   logic [3:0] len0, len1, len2;
   logic [7:0] dado0, dado1, dado2;
   logic       pronto_tx;
   logic [2:0] grant;
   logic [3:0] byte_idx;
   logic [2:0] fim;
   logic       partida_tx;
   logic [7:0] dado_tx;
   logic       erro_tx;
   logic       ocupado;
   logic [2:0] db_estado;

   logic [7:0] msg0 [16];
   logic [7:0] msg1 [16];
   logic [7:0] msg2 [16];

   int n_checks;
   int n_fail;
   logic tx_enable;
   int   tx_delay;

   typedef struct {
      logic       is_end;
      logic [2:0] who;
      logic [7:0] data;
   } ev_t;

   ev_t sb [$];
   ev_t mon_ev;

   serial_tx_arbiter #(
      .TIMEOUT(8),
      .CW     (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .len0      (len0),
      .len1      (len1),
      .len2      (len2),
      .dado0     (dado0),
      .dado1     (dado1),
      .dado2     (dado2),
      .pronto_tx (pronto_tx),
      .grant     (grant),
      .byte_idx  (byte_idx),
      .fim       (fim),
      .partida_tx(partida_tx),
      .dado_tx   (dado_tx),
      .erro_tx   (erro_tx),
      .ocupado   (ocupado),
      .db_estado (db_estado)
   );

   assign dado0 = msg0[byte_idx];
   assign dado1 = msg1[byte_idx];
   assign dado2 = msg2[byte_idx];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name, input string msg);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s at %0t", name, msg, $time);
   endtask

   task automatic push_byte(input logic [2:0] who, input logic [7:0] d);
      ev_t e;
      e.is_end = 1'b0;
      e.who    = who;
      e.data   = d;
      sb.push_back(e);
   endtask

   task automatic push_end(input logic [2:0] who, input logic err);
      ev_t e;
      e.is_end = 1'b1;
      e.who    = who;
      e.data   = {7'd0, err};
      sb.push_back(e);
   endtask

   task automatic check_state(input string name, input logic [2:0] s);
      check(name, 32'(db_estado), 32'(s));
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || db_estado != 3'd0) && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (n >= 400) flag(name, "timeout waiting for idle");
   endtask

   task automatic wait_idx(input logic [3:0] v);
      int n;
      n = 0;
      while (byte_idx != v && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) flag("wait_idx", "byte_idx never reached target");
   endtask

   task automatic wait_fim(input logic [2:0] v);
      int n;
      n = 0;
      while (fim != v && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) flag("wait_fim", "fim never pulsed");
   endtask

   // Transmitter model: pronto_tx pulses tx_delay cycles after each partida_tx.
   initial begin
      pronto_tx = 1'b0;
      forever begin
         @(negedge clock);
         if (partida_tx && tx_enable) begin
            repeat (tx_delay) @(negedge clock);
            pronto_tx = 1'b1;
            @(negedge clock);
            pronto_tx = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (partida_tx) begin
         if (sb.size() == 0) begin
            flag("unexpected_partida", "partida_tx with nothing expected");
         end else begin
            mon_ev = sb.pop_front();
            check("byte_kind", 32'(mon_ev.is_end), 32'd0);
            check("byte_grant", 32'(grant), 32'(mon_ev.who));
            check("byte_data", 32'(dado_tx), 32'(mon_ev.data));
         end
      end
      if (fim != 3'b000) begin
         if (sb.size() == 0) begin
            flag("unexpected_fim", "fim pulse with nothing expected");
         end else begin
            mon_ev = sb.pop_front();
            check("end_kind", 32'(mon_ev.is_end), 32'd1);
            check("end_fim", 32'(fim), 32'(mon_ev.who));
            check("end_erro", 32'(erro_tx), 32'(mon_ev.data[0]));
         end
      end
      if (erro_tx && fim == 3'b000) flag("erro_without_fim", "erro_tx pulsed alone");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      req       = 3'b000;
      len0      = 4'd0;
      len1      = 4'd0;
      len2      = 4'd0;
      tx_enable = 1'b1;
      tx_delay  = 5;
      for (int i = 0; i < 16; i++) begin
         msg0[i] = 8'd0;
         msg1[i] = 8'd0;
         msg2[i] = 8'd0;
      end
      repeat (3) @(negedge clock);
      check_state("rst_state", 3'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_fim", 32'(fim), 32'd0);
      check("rst_partida", 32'(partida_tx), 32'd0);
      check("rst_erro", 32'(erro_tx), 32'd0);
      check("rst_ocupado", 32'(ocupado), 32'd0);
      check("rst_idx", 32'(byte_idx), 32'd0);
      check("rst_dado", 32'(dado_tx), 32'd0);
      reset = 1'b0;

      // Single source, three bytes A0..A2
      for (int i = 0; i < 16; i++) msg0[i] = 8'(8'hA0 + i);
      len0 = 4'd3;
      push_byte(3'b001, 8'hA0);
      push_byte(3'b001, 8'hA1);
      push_byte(3'b001, 8'hA2);
      push_end(3'b001, 1'b0);
      req = 3'b001;
      @(negedge clock);
      check_state("single_carrega", 3'd1);
      check("single_grant", 32'(grant), 32'b001);
      req = 3'b000;
      @(negedge clock);
      check_state("single_envia", 3'd2);
      check("single_partida", 32'(partida_tx), 32'd1);
      @(negedge clock);
      check_state("single_espera", 3'd3);
      wait_done("single_done");

      // Round-robin from reset: order 0,1,2,0
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      len0 = 4'd1;
      len1 = 4'd1;
      len2 = 4'd1;
      msg0[0] = 8'h10;
      msg1[0] = 8'h11;
      msg2[0] = 8'h12;
      push_byte(3'b001, 8'h10);
      push_end(3'b001, 1'b0);
      push_byte(3'b010, 8'h11);
      push_end(3'b010, 1'b0);
      push_byte(3'b100, 8'h12);
      push_end(3'b100, 1'b0);
      push_byte(3'b001, 8'h10);
      push_end(3'b001, 1'b0);
      req = 3'b111;
      for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clock);
      req = 3'b000;
      wait_done("rr_done");

      // Source 0 sends 4 bytes; source 2 requests mid-message and waits its turn
      for (int i = 0; i < 16; i++) msg0[i] = 8'(8'hB0 + i);
      msg2[0] = 8'hC5;
      len0 = 4'd4;
      len2 = 4'd1;
      for (int i = 0; i < 4; i++) push_byte(3'b001, 8'(8'hB0 + i));
      push_end(3'b001, 1'b0);
      push_byte(3'b100, 8'hC5);
      push_end(3'b100, 1'b0);
      req = 3'b001;
      @(negedge clock);
      req = 3'b000;
      wait_idx(4'd1);
      req = 3'b100;
      @(negedge clock);
      check("mid_grant_held", 32'(grant), 32'b001);
      wait_fim(3'b001);
      @(negedge clock);
      check_state("mid_inicial", 3'd0);
      @(negedge clock);
      check_state("mid_regrant_state", 3'd1);
      check("mid_regrant", 32'(grant), 32'b100);
      req = 3'b000;
      wait_done("mid_done");

      // Zero-length message
      len1 = 4'd0;
      push_end(3'b010, 1'b0);
      req = 3'b010;
      @(negedge clock);
      check_state("zero_fim_state", 3'd4);
      check("zero_fim", 32'(fim), 32'b010);
      check("zero_partida", 32'(partida_tx), 32'd0);
      req = 3'b000;
      @(negedge clock);
      check_state("zero_inicial", 3'd0);

      // Timeout: no pronto_tx, ERRO 8 cycles after ESPERA entry
      tx_enable = 1'b0;
      for (int i = 0; i < 16; i++) msg0[i] = 8'(8'hD0 + i);
      len0 = 4'd2;
      push_byte(3'b001, 8'hD0);
      push_end(3'b001, 1'b1);
      req = 3'b001;
      @(negedge clock);
      req = 3'b000;
      @(negedge clock);
      @(negedge clock);
      check_state("to_espera_entry", 3'd3);
      repeat (7) @(negedge clock);
      check_state("to_still_espera", 3'd3);
      @(negedge clock);
      check_state("to_erro_state", 3'd5);
      check("to_erro_tx", 32'(erro_tx), 32'd1);
      check("to_fim", 32'(fim), 32'b001);
      @(negedge clock);
      check_state("to_back_idle", 3'd0);
      tx_enable = 1'b1;
      push_byte(3'b100, 8'hC5);
      push_end(3'b100, 1'b0);
      req = 3'b100;
      @(negedge clock);
      req = 3'b000;
      wait_done("after_to_done");

      // pronto_tx on the timeout cycle counts as success
      tx_delay = 8;
      len0 = 4'd1;
      push_byte(3'b001, 8'hD0);
      push_end(3'b001, 1'b0);
      req = 3'b001;
      @(negedge clock);
      req = 3'b000;
      @(negedge clock);
      @(negedge clock);
      check_state("edge_espera", 3'd3);
      repeat (7) @(negedge clock);
      check_state("edge_last_cycle", 3'd3);
      @(negedge clock);
      check_state("edge_fim_state", 3'd4);
      check("edge_no_erro", 32'(erro_tx), 32'd0);
      tx_delay = 5;
      wait_done("edge_done");

      // Reset while in ESPERA aborts silently
      tx_enable = 1'b0;
      len1 = 4'd3;
      msg1[0] = 8'h5A;
      push_byte(3'b010, 8'h5A);
      req = 3'b010;
      @(negedge clock);
      req = 3'b000;
      @(negedge clock);
      @(negedge clock);
      repeat (2) @(negedge clock);
      check_state("rstmid_pre", 3'd3);
      reset = 1'b1;
      @(negedge clock);
      check_state("rstmid_state", 3'd0);
      check("rstmid_grant", 32'(grant), 32'd0);
      check("rstmid_fim", 32'(fim), 32'd0);
      check("rstmid_ocupado", 32'(ocupado), 32'd0);
      check("rstmid_partida", 32'(partida_tx), 32'd0);
      check("rstmid_erro", 32'(erro_tx), 32'd0);
      check("rstmid_idx", 32'(byte_idx), 32'd0);
      check("rstmid_dado", 32'(dado_tx), 32'd0);
      reset = 1'b0;
      tx_enable = 1'b1;
      repeat (12) @(negedge clock);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares the single serial transmitter between three message sources: measurement report (0), config acknowledgement (1) and alarm (2). Selects one requester round-robin, latches its message length, streams its bytes to the transmitter one at a time under the `partida_tx`/`pronto_tx` handshake, and signals completion or timeout back to the winner. It sits between the requester FSMs (including the config manager's ack path) and the serial TX unit.

## Interface
- `TIMEOUT`, default 50000: maximum cycles to wait for `pronto_tx` after each `partida_tx`.
- `CW`, default 16: width of the timeout counter; `TIMEOUT` must be ≤ 2^CW.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  3  request per source; bit i = source i.
- `len0`, `len1`, `len2`  in  4 each  message length in bytes (0..15), sampled at grant.
- `dado0`, `dado1`, `dado2`  in  8 each  byte at index `byte_idx`, driven by source while granted.
- `pronto_tx`  in  1  transmitter finished the current byte (one-cycle pulse).
- `grant`  out  3  one-hot, held for the whole message.
- `byte_idx`  out  4  index of the byte currently requested.
- `fim`  out  3  one-cycle pulse to the granted source at end of message (normal or error).
- `partida_tx`  out  1  one-cycle start pulse to transmitter.
- `dado_tx`  out  8  registered byte to transmit; stable from CARREGA until next CARREGA.
- `erro_tx`  out  1  one-cycle pulse: message aborted by timeout.
- `ocupado`  out  1  high in every state except INICIAL.
- `db_estado`  out  3  current state encoding.

## Operation
- States (encoding): INICIAL=0, CARREGA=1, ENVIA=2, ESPERA=3, FIM=4, ERRO=5; codes 6-7 → INICIAL.
- Registers: `ptr` (last served, 2 bits), `sel` (granted, 2 bits), `len_lat` (4), `byte_idx` (4), `dado_tx` (8), timeout counter (CW).
- INICIAL: if `req` ≠ 0, pick first set bit in order ptr+1, ptr+2, ptr+3 (mod 3); latch `sel` and `len_lat` from that source's `len`; `byte_idx`←0; → CARREGA (or → FIM directly if latched length is 0). Else stay.
- CARREGA: `dado_tx`←dado[sel]; → ENVIA.
- ENVIA: `partida_tx`=1; clear counter; → ESPERA.
- ESPERA: on `pronto_tx`: if `byte_idx` == `len_lat`−1 → FIM, else `byte_idx`++ and → CARREGA. Else counter++; when counter == TIMEOUT−1 and no `pronto_tx` → ERRO. `pronto_tx` on the timeout cycle wins (treated as success).
- FIM: `fim[sel]`=1; `ptr`←`sel`; → INICIAL.
- ERRO: `fim[sel]`=1, `erro_tx`=1; `ptr`←`sel`; → INICIAL.
- `grant` = one-hot of `sel` in CARREGA, ENVIA, ESPERA, FIM, ERRO; 0 in INICIAL.
- `req` changes while granted are ignored; message runs to completion. A source still requesting after `fim` competes again normally.
- `pronto_tx` outside ESPERA is ignored.
- Reset values: state INICIAL, `ptr`=2 (source 0 wins first tie), `sel`=0, `byte_idx`=0, `dado_tx`=0, counter 0; `grant`, `fim`, `partida_tx`, `erro_tx`, `ocupado` = 0. Reset mid-message aborts without `fim`.

## Timing
- Request seen in INICIAL at cycle t → `grant` high at t+1 (CARREGA), `partida_tx` at t+2, ESPERA from t+3.
- `pronto_tx` at cycle p on non-last byte → CARREGA at p+1, next `partida_tx` at p+2.
- `pronto_tx` on last byte at p → `fim` at p+1, INICIAL at p+2; a pending request is granted at p+3.
- Byte overhead: 3 cycles plus transmitter time; zero-length message: grant t+1 (FIM, `fim` pulses), INICIAL t+2.
- Timeout: ERRO exactly TIMEOUT cycles after first ESPERA cycle with no `pronto_tx`.

## Test plan
- Single source: `req`=001, `len0`=3, dado0 = 0xA0+idx, `pronto_tx` 5 cycles after each `partida_tx` → `dado_tx` sequence A0,A1,A2; three `partida_tx` pulses; `fim`=001 once; `erro_tx` never.
- Round-robin: `req`=111 held, all lengths 1 → grant order 0,1,2,0; `ptr` after reset favours 0.
- Mid-message request: source 0 sending 4 bytes, `req[2]` rises at byte 1 → source 0 finishes all 4 before `grant`=100.
- Zero length: `req`=010, `len1`=0 → `fim`=010 at t+1, no `partida_tx`.
- Timeout: TIMEOUT=8, never pulse `pronto_tx` → ERRO 8 cycles after ESPERA entry; `erro_tx` and `fim[sel]` pulse same cycle; next request serviced normally.
- Reset mid-ESPERA → next cycle state 0, all outputs 0, no `fim`; `pronto_tx` on timeout cycle → success path, not ERRO.
